// File: rtl/xbox_xlr_blkmov.sv
// Block-move accelerator on the XBOX memory interface: FILL / COPY / SUM over a
// line range, programmed through host registers 0..4, status and checksum in 8/9.
module xbox_xlr_blkmov #(
  parameter int NUM_MEMS           = 2,
  parameter int LOG2_LINES_PER_MEM = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  output logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0]    xlr_mem_addr,
  output logic [NUM_MEMS-1:0][7:0][31:0]                 xlr_mem_wdata,
  output logic [NUM_MEMS-1:0][31:0]                      xlr_mem_be,
  output logic [NUM_MEMS-1:0]                            xlr_mem_rd,
  output logic [NUM_MEMS-1:0]                            xlr_mem_wr,
  input  logic [NUM_MEMS-1:0][7:0][31:0]                 xlr_mem_rdata,
  input  logic [31:0][31:0]                              host_regs,
  input  logic [31:0]                                    host_regs_valid_pulse,
  output logic [31:0][31:0]                              host_regs_data_out,
  output logic [31:0]                                    host_regs_valid_out,
  input  logic [18:0]                                    trig_soc_xmem_wr_addr,
  input  logic                                           trig_soc_xmem_wr
);

  localparam int          LW      = LOG2_LINES_PER_MEM;
  localparam logic [16:0] MAX_LEN = 17'(1) << LW;
  localparam logic [8:0]  NM      = 9'(NUM_MEMS);

  localparam logic [1:0] MODE_FILL = 2'd0;
  localparam logic [1:0] MODE_COPY = 2'd1;
  localparam logic [1:0] MODE_SUM  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RD, S_WR, S_ACC, S_FIN} state_t;

  state_t         state_q;
  logic [1:0]     mode_q;
  logic [7:0]     src_mem_q, dst_mem_q;
  logic [LW-1:0]  src_line_q, dst_line_q;
  logic [15:0]    rem_q, lines_q;
  logic [31:0]    pattern_q, sum_q;
  logic           done_q, err_q, vld_q;

  logic           start_req, req_err;
  logic [1:0]     req_mode;
  logic [15:0]    req_len;
  logic [7:0][31:0] src_rdata;
  logic [31:0]    line_sum;
  logic           busy;
  logic           unused_inputs;

  assign unused_inputs = ^{trig_soc_xmem_wr_addr, trig_soc_xmem_wr,
                           host_regs, host_regs_valid_pulse};

  // Start decode: only the memories the selected mode actually touches are range-checked.
  always_comb begin
    start_req = host_regs_valid_pulse[0] & host_regs[0][0];
    req_mode  = host_regs[0][2:1];
    req_len   = host_regs[3][15:0];
    req_err   = (req_mode == MODE_RSVD)
              | (((req_mode == MODE_COPY) | (req_mode == MODE_SUM))
                 & ({1'b0, host_regs[1][7:0]} >= NM))
              | (((req_mode == MODE_COPY) | (req_mode == MODE_FILL))
                 & ({1'b0, host_regs[2][7:0]} >= NM))
              | ({1'b0, req_len} > MAX_LEN);
  end

  always_comb begin
    src_rdata = '0;
    for (int m = 0; m < NUM_MEMS; m++) begin
      if (src_mem_q == 8'(m)) src_rdata = xlr_mem_rdata[m];
    end
    line_sum = '0;
    for (int w = 0; w < 8; w++) line_sum = line_sum + src_rdata[w];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_FILL;
      src_mem_q  <= '0;
      dst_mem_q  <= '0;
      src_line_q <= '0;
      dst_line_q <= '0;
      rem_q      <= '0;
      lines_q    <= '0;
      pattern_q  <= '0;
      sum_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      vld_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start_req) begin
            mode_q     <= req_mode;
            src_mem_q  <= host_regs[1][7:0];
            dst_mem_q  <= host_regs[2][7:0];
            src_line_q <= host_regs[1][8 +: LW];
            dst_line_q <= host_regs[2][8 +: LW];
            rem_q      <= req_len;
            pattern_q  <= host_regs[4];
            sum_q      <= '0;
            lines_q    <= '0;
            err_q      <= req_err;
            done_q     <= req_err | (req_len == 16'd0);
            if (!req_err && req_len != 16'd0)
              state_q <= (req_mode == MODE_FILL) ? S_FILL : S_RD;
          end
        end
        S_FILL: begin
          dst_line_q <= dst_line_q + LW'(1);
          lines_q    <= lines_q + 16'd1;
          rem_q      <= rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end
        end
        S_RD: begin
          src_line_q <= src_line_q + LW'(1);
          state_q    <= (mode_q == MODE_COPY) ? S_WR : S_ACC;
        end
        S_WR, S_ACC: begin
          if (state_q == S_WR) dst_line_q <= dst_line_q + LW'(1);
          sum_q   <= sum_q + line_sum;
          lines_q <= lines_q + 16'd1;
          rem_q   <= rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_RD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from registered state so an async reset silences them at once.
  always_comb begin
    xlr_mem_addr  = '0;
    xlr_mem_wdata = '0;
    xlr_mem_be    = '0;
    xlr_mem_rd    = '0;
    xlr_mem_wr    = '0;
    for (int m = 0; m < NUM_MEMS; m++) begin
      if (state_q == S_RD && src_mem_q == 8'(m)) begin
        xlr_mem_rd[m]   = 1'b1;
        xlr_mem_addr[m] = src_line_q;
      end
      if ((state_q == S_FILL || state_q == S_WR) && dst_mem_q == 8'(m)) begin
        xlr_mem_wr[m]    = 1'b1;
        xlr_mem_addr[m]  = dst_line_q;
        xlr_mem_be[m]    = '1;
        xlr_mem_wdata[m] = (state_q == S_FILL) ? {8{pattern_q}} : src_rdata;
      end
    end
  end

  assign busy = (state_q == S_FILL) | (state_q == S_RD) |
                (state_q == S_WR)   | (state_q == S_ACC);

  always_comb begin
    host_regs_data_out    = '0;
    host_regs_data_out[8] = {lines_q, 13'b0, err_q, done_q, busy};
    host_regs_data_out[9] = sum_q;
    host_regs_valid_out    = '0;
    host_regs_valid_out[8] = vld_q;
    host_regs_valid_out[9] = vld_q;
  end

endmodule

// File: tb/tb_xbox_xlr_blkmov.sv
// Directed bench for xbox_xlr_blkmov with a two-instance, 16-line memory model.
module tb_xbox_xlr_blkmov;

  logic                  clk;
  logic                  rst_n;
  logic [1:0][3:0]       addr;
  logic [1:0][7:0][31:0] wdata;
  logic [1:0][31:0]      be;
  logic [1:0]            rd;
  logic [1:0]            wr;
  logic [1:0][7:0][31:0] rdata;
  logic [31:0][31:0]     hregs;
  logic [31:0]           hpulse;
  logic [31:0][31:0]     dout;
  logic [31:0]           vout;
  logic [18:0]           trig_addr;
  logic                  trig_wr;

  logic [31:0] mem [2][16][8];
  int checks = 0;
  int errors = 0;

  xbox_xlr_blkmov #(.NUM_MEMS(2), .LOG2_LINES_PER_MEM(4)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .xlr_mem_addr          (addr),
    .xlr_mem_wdata         (wdata),
    .xlr_mem_be            (be),
    .xlr_mem_rd            (rd),
    .xlr_mem_wr            (wr),
    .xlr_mem_rdata         (rdata),
    .host_regs             (hregs),
    .host_regs_valid_pulse (hpulse),
    .host_regs_data_out    (dout),
    .host_regs_valid_out   (vout),
    .trig_soc_xmem_wr_addr (trig_addr),
    .trig_soc_xmem_wr      (trig_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mem0 line l word w holds l*8+w+1 while reset is held; mem1 starts zeroed.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      for (int w = 0; w < 8; w++) begin
        if (!rst_n) begin
          for (int l = 0; l < 16; l++) mem[m][l][w] <= (m == 0) ? 32'(l * 8 + w + 1) : 32'h0;
        end else begin
          if (wr[m]) mem[m][addr[m]][w] <= wdata[m][w];
          if (rd[m]) rdata[m][w] <= mem[m][addr[m]][w];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] ctrl, input logic [31:0] src,
                           input logic [31:0] dst, input logic [31:0] len,
                           input logic [31:0] pat);
    hregs[0] = ctrl;
    hregs[1] = src;
    hregs[2] = dst;
    hregs[3] = len;
    hregs[4] = pat;
    hpulse   = 32'h1F;
    step();
    hpulse   = '0;
  endtask

  initial begin
    rst_n     = 1'b0;
    hregs     = '0;
    hpulse    = '0;
    trig_addr = '0;
    trig_wr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_status", dout[8], 32'h0);
    chk("rst_sum", dout[9], 32'h0);
    chk("rst_strobes", {28'b0, rd, wr}, 32'h0);
    chk("rst_vout", vout, 32'h0);
    rst_n = 1'b1;
    step();
    chk("vout", vout, 32'h0000_0300);
    chk("idle_status", dout[8], 32'h0);

    // FILL mem1 lines 3..6
    start_job(32'h1, 32'h0, 32'h0000_0301, 32'd4, 32'hA5A5_0001);
    chk("fill_busy", dout[8], 32'h0000_0001);
    for (int k = 0; k < 4; k++) begin
      chk("fill_wr", {28'b0, rd, wr}, 32'h2);
      chk("fill_addr", 32'(addr[1]), 32'(k + 3));
      chk("fill_addr0", 32'(addr[0]), 32'h0);
      chk("fill_be", be[1], 32'hFFFF_FFFF);
      chk("fill_be0", be[0], 32'h0);
      chk("fill_wd0", wdata[1][0], 32'hA5A5_0001);
      chk("fill_wd7", wdata[1][7], 32'hA5A5_0001);
      step();
    end
    chk("fill_status", dout[8], 32'h0004_0002);
    chk("fill_idle", {28'b0, rd, wr}, 32'h0);
    for (int l = 3; l < 7; l++) chk("fill_mem", mem[1][l][5], 32'hA5A5_0001);

    // SUM of mem0 lines 0..1 (words 1..16)
    step();
    start_job(32'h5, 32'h0, 32'h0, 32'd2, 32'h0);
    for (int k = 0; k < 2; k++) begin
      chk("sum_rd", {28'b0, rd, wr}, 32'h4);
      chk("sum_addr", 32'(addr[0]), 32'(k));
      step();
      chk("sum_acc_nostrobe", {28'b0, rd, wr}, 32'h0);
      step();
    end
    chk("sum_status", dout[8], 32'h0002_0002);
    chk("sum_value", dout[9], 32'd136);

    // COPY mem0 14,15,0 -> mem1 0,1,2 with a start pulse and LEN rewrite mid-job
    step();
    start_job(32'h3, 32'h0000_0E00, 32'h0000_0001, 32'd3, 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("copy_rd", {28'b0, rd, wr}, 32'h4);
      chk("copy_rd_addr", 32'(addr[0]), 32'((14 + k) % 16));
      step();
      chk("copy_wr", {28'b0, rd, wr}, 32'h2);
      chk("copy_wr_addr", 32'(addr[1]), 32'(k));
      chk("copy_wdata", wdata[1][2], 32'(((14 + k) % 16) * 8 + 3));
      chk("copy_be", be[1], 32'hFFFF_FFFF);
      if (k == 0) begin
        hregs[0] = 32'h1;
        hregs[3] = 32'h1;
        hpulse   = 32'h9;
      end
      step();
      hpulse = '0;
    end
    chk("copy_status", dout[8], 32'h0003_0002);
    chk("copy_sum", dout[9], 32'd1964);
    chk("copy_idle", {28'b0, rd, wr}, 32'h0);
    chk("copy_mem_l0", mem[1][0][0], 32'd113);
    chk("copy_mem_l1", mem[1][1][4], 32'd125);
    chk("copy_mem_l2", mem[1][2][7], 32'd8);

    // Start-time errors and LEN=0
    step();
    start_job(32'h1, 32'h0, 32'h0000_0002, 32'd1, 32'h0);
    chk("err_mem_status", dout[8], 32'h0000_0006);
    chk("err_mem_strobes", {28'b0, rd, wr}, 32'h0);
    step();
    chk("err_mem_quiet", {28'b0, rd, wr}, 32'h0);
    chk("err_mem_sticky", dout[8], 32'h0000_0006);
    start_job(32'h3, 32'h0, 32'h0000_0001, 32'd17, 32'h0);
    chk("err_len_status", dout[8], 32'h0000_0006);
    chk("err_len_strobes", {28'b0, rd, wr}, 32'h0);
    start_job(32'h7, 32'h0, 32'h0, 32'd1, 32'h0);
    chk("err_mode_status", dout[8], 32'h0000_0006);
    chk("err_mode_strobes", {28'b0, rd, wr}, 32'h0);
    chk("err_sum_cleared", dout[9], 32'h0);
    start_job(32'h1, 32'h0, 32'h0000_0001, 32'd0, 32'h0);
    chk("len0_status", dout[8], 32'h0000_0002);
    chk("len0_strobes", {28'b0, rd, wr}, 32'h0);

    // Reset in the middle of a COPY
    step();
    start_job(32'h3, 32'h0, 32'h0000_0501, 32'd4, 32'h0);
    chk("mid_rd", {28'b0, rd, wr}, 32'h4);
    step();
    chk("mid_wr", {28'b0, rd, wr}, 32'h2);
    step();
    chk("mid_sum", dout[9], 32'd36);
    chk("mid_status", dout[8], 32'h0001_0001);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {28'b0, rd, wr}, 32'h0);
    chk("mid_rst_status", dout[8], 32'h0);
    chk("mid_rst_sum", dout[9], 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    start_job(32'h1, 32'h0, 32'h0000_0900, 32'd1, 32'hDEAD_BEEF);
    chk("post_wr", {28'b0, rd, wr}, 32'h1);
    chk("post_addr", 32'(addr[0]), 32'd9);
    chk("post_wdata", wdata[0][4], 32'hDEAD_BEEF);
    step();
    chk("post_status", dout[8], 32'h0001_0002);
    chk("post_mem", mem[0][9][4], 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
